// File: rtl/gates4_sweep_checker.sv
// gates4_sweep_checker: drives all 16 vectors into a 4-input AND/NAND/OR/NOR block and checks its outputs.
module gates4_sweep_checker #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       drv_in0,
    output logic       drv_in1,
    output logic       drv_in2,
    output logic       drv_in3,
    input  logic       chk_and,
    input  logic       chk_nand,
    input  logic       chk_or,
    input  logic       chk_nor,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] err_mask,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;
    localparam logic [2:0] LAST = 3'(SETTLE == 0 ? 0 : SETTLE - 1);
    // With no settle time each vector goes straight to its check cycle.
    localparam state_t RUN = (SETTLE == 0) ? S_CHECK : S_SETTLE;
    state_t state, state_n;
    logic [3:0] vec;
    logic [2:0] cnt;
    logic [3:0] expect_v, got, diff;
    logic       mis;
    logic [4:0] err_next;
    assign expect_v = {~|vec, |vec, ~&vec, &vec};
    assign got      = {chk_nor, chk_or, chk_nand, chk_and};
    assign diff     = expect_v ^ got;
    assign mis      = |diff;
    assign err_next = err_count + 5'(mis);
    assign busy     = (state == S_SETTLE) || (state == S_CHECK);
    assign done     = state == S_DONE;
    assign {drv_in3, drv_in2, drv_in1, drv_in0} = busy ? vec : 4'd0;
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   state_n = start ? RUN : S_IDLE;
            S_SETTLE: state_n = (cnt == LAST) ? S_CHECK : S_SETTLE;
            S_CHECK:  state_n = (vec == 4'hf) ? S_DONE : RUN;
            default:  state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            vec             <= 4'd0;
            cnt             <= 3'd0;
            pass            <= 1'b0;
            err_count       <= 5'd0;
            err_mask        <= 4'd0;
            first_err_vec   <= 4'd0;
            first_err_valid <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (start) begin
                    vec             <= 4'd0;
                    cnt             <= 3'd0;
                    pass            <= 1'b0;
                    err_count       <= 5'd0;
                    err_mask        <= 4'd0;
                    first_err_valid <= 1'b0;
                end
                S_SETTLE: cnt <= cnt + 3'd1;
                S_CHECK: begin
                    if (mis) begin
                        err_count <= err_next;
                        err_mask  <= err_mask | diff;
                        if (!first_err_valid) begin
                            first_err_vec   <= vec;
                            first_err_valid <= 1'b1;
                        end
                    end
                    // pass is registered on entry to DONE so it is valid in the done cycle.
                    if (vec == 4'hf) pass <= (err_next == 5'd0);
                    else begin
                        vec <= vec + 4'd1;
                        cnt <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gates4_sweep_checker.sv
// tb_gates4_sweep_checker: directed runs on SETTLE=1 and SETTLE=0 instances with faulty and lagging gate models.
module tb_gates4_sweep_checker;
    logic clk = 1'b0;
    logic reset_n;
    logic start0, start1;
    logic [3:0] drv0, drv1, g0, g1, lag;
    logic busy0, done0, pass0, fvv0, busy1, done1, pass1, fvv1;
    logic [4:0] ec0, ec1;
    logic [3:0] em0, em1, fv0, fv1;
    int mode, tests, fails;
    bit cur;
    logic [3:0] o_drv, o_em, o_fv;
    logic [4:0] o_ec;
    logic o_busy, o_done, o_pass, o_fvv;

    always #5 clk = ~clk;

    function automatic logic [3:0] gates(input logic [3:0] v);
        return {~|v, |v, ~&v, &v};
    endfunction

    always_ff @(posedge clk) lag <= gates(drv1);
    assign g0 = gates(drv0);
    assign g1 = mode == 0 ? gates(drv1) : mode == 1 ? gates(drv1) & 4'b1110 :
                mode == 2 ? gates(drv1) ^ 4'b1000 : lag;

    assign o_drv  = cur ? drv0 : drv1;
    assign o_busy = cur ? busy0 : busy1;
    assign o_done = cur ? done0 : done1;
    assign o_pass = cur ? pass0 : pass1;
    assign o_ec   = cur ? ec0 : ec1;
    assign o_em   = cur ? em0 : em1;
    assign o_fv   = cur ? fv0 : fv1;
    assign o_fvv  = cur ? fvv0 : fvv1;

    gates4_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .drv_in0(drv1[0]), .drv_in1(drv1[1]), .drv_in2(drv1[2]), .drv_in3(drv1[3]),
        .chk_and(g1[0]), .chk_nand(g1[1]), .chk_or(g1[2]), .chk_nor(g1[3]),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .err_mask(em1),
        .first_err_vec(fv1), .first_err_valid(fvv1)
    );

    gates4_sweep_checker #(.SETTLE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .drv_in0(drv0[0]), .drv_in1(drv0[1]), .drv_in2(drv0[2]), .drv_in3(drv0[3]),
        .chk_and(g0[0]), .chk_nand(g0[1]), .chk_or(g0[2]), .chk_nor(g0[3]),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .err_mask(em0),
        .first_err_vec(fv0), .first_err_valid(fvv0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle k counts periods after the edge that samples start; done is expected at k = exp_done.
    task automatic run(input bit sel, input bit hold, input int exp_done, input logic [4:0] ec,
                       input logic [3:0] em, input logic [3:0] fv, input bit fvv, input bit ps);
        int span = sel ? 1 : 2;
        int dk = 0;
        cur = sel;
        @(negedge clk);
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40 && dk == 0; k++) begin
            @(negedge clk);
            if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
            if (o_done) dk = k;
            else if (k < exp_done) begin
                check("drv", 32'(o_drv), 32'((k - 1) / span));
                check("busy", 32'(o_busy), 1);
            end
        end
        check("done_cycle", dk, exp_done);
        check("busy_in_done", 32'(o_busy), 0);
        check("pass", 32'(o_pass), 32'(ps));
        check("err_count", 32'(o_ec), 32'(ec));
        check("err_mask", 32'(o_em), 32'(em));
        check("first_valid", 32'(o_fvv), 32'(fvv));
        if (fvv) check("first_vec", 32'(o_fv), 32'(fv));
        if (hold) begin
            @(negedge clk);
            check("idle_after_done", {o_busy, o_done}, 0);
            @(negedge clk);
            check("restart_busy", 32'(o_busy), 1);
            check("restart_cleared", {o_ec, o_em, o_fvv, o_pass}, 0);
            start1 = 1'b0;
        end
    endtask

    initial begin
        tests = 0; fails = 0; mode = 0; cur = 0;
        reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        #12;
        check("reset_outputs1", {busy1, done1, pass1, ec1, em1, fv1, fvv1, drv1}, 0);
        check("reset_outputs0", {busy0, done0, pass0, ec0, em0, fv0, fvv0, drv0}, 0);
        @(negedge clk) reset_n = 1'b1;
        mode = 0; run(0, 0, 33, 5'd0, 4'd0, 4'd0, 0, 1);
        mode = 1; run(0, 0, 33, 5'd1, 4'b0001, 4'd15, 1, 0);
        mode = 2; run(0, 0, 33, 5'd16, 4'b1000, 4'd0, 1, 0);
        mode = 3; run(0, 0, 33, 5'd0, 4'd0, 4'd0, 0, 1);
        mode = 0; run(1, 0, 17, 5'd0, 4'd0, 4'd0, 0, 1);
        mode = 1; run(0, 1, 33, 5'd1, 4'b0001, 4'd15, 1, 0);
        for (int i = 0; i < 40 && drv1 != 4'd7; i++) @(negedge clk);
        check("reach_vec7", 32'(drv1), 7);
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {busy1, done1, pass1, ec1, em1, fv1, fvv1, drv1}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_in_reset", {busy1, done1}, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("no_done_after_abort", {busy1, done1}, 0);
        mode = 0; run(0, 0, 33, 5'd0, 4'd0, 4'd0, 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
